neuron_lut_loader: RTL
======================

NEURON_LUT_LOADER -- requirements
Module: neuron_lut_loader

Interface
REQ-001 Parameter IN_W, 6, neuron fan-in width; table depth is 2**IN_W.
REQ-002 Parameter BEAT_W, 8, truth-table bits delivered per configuration beat; 2**IN_W is a multiple of BEAT_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  input  1  configuration beat valid.
REQ-006 cfg_ready  output  1  configuration beat accepted when cfg_valid and cfg_ready are both high.
REQ-007 cfg_data  input  BEAT_W  truth-table bits; bit j of beat k is the entry at index k*BEAT_W+j.
REQ-008 cfg_last  input  1  marks the final beat of a table load.
REQ-009 cfg_err  output  1  one-cycle pulse on a malformed load.
REQ-010 loaded  output  1  high while a complete, valid table is held.
REQ-011 in_valid / in_ready  input / output  1 / 1  lookup request handshake.
REQ-012 in_data  input  IN_W  lookup address; unsigned index into the table.
REQ-013 out_valid / out_ready  output / input  1 / 1  lookup result handshake.
REQ-014 out_data  output  1  table bit at the accepted in_data.

Function
REQ-015 The FSM has exactly three states: EMPTY, LOADING and READY.
REQ-016 In EMPTY: cfg_ready=1, in_ready=0; an accepted beat writes beat 0 and moves to LOADING, or to READY if a single beat completes the table.
REQ-017 In LOADING: cfg_ready=1, in_ready=0; each accepted beat writes the next BEAT_W entries and increments the beat counter.
REQ-018 The final beat (index 2**IN_W/BEAT_W-1) with cfg_last=1 moves the FSM to READY and sets loaded=1 on the next cycle.
REQ-019 cfg_last=1 on a non-final beat, or cfg_last=0 on the final beat, pulses cfg_err for one cycle, clears the beat counter and loaded, and returns the FSM to EMPTY.
REQ-020 In READY: in_ready = !out_valid || out_ready.
REQ-021 An accepted lookup registers out_data = table[in_data] and sets out_valid on the next cycle (latency 1).
REQ-022 out_valid and out_data hold stable until out_ready is high, and back-to-back lookups sustain one result per cycle.
REQ-023 In READY: cfg_ready = !out_valid && !in_valid, so a pending lookup has priority over reload.
REQ-024 A beat accepted in READY starts a reload, clears loaded, and moves the FSM to LOADING (or to READY again if a single beat completes the table).
REQ-025 A table write and a lookup never occur in the same cycle.
REQ-026 The beat counter is ceil(log2(2**IN_W/BEAT_W)) bits wide; it resets to 0 on completion or error and never wraps silently.

Reset
REQ-027 While rst_n=0: FSM=EMPTY, beat counter=0, every table bit=0, and all outputs are 0, except cfg_ready, which is 1 as in EMPTY.
REQ-028 Reset asserted mid-load or mid-lookup discards the partial table and any pending result immediately.
REQ-029 After rst_n deasserts, the first beat is accepted no earlier than the first rising edge.

Structure
REQ-030 The shared package neuron_lut_pkg holds the FSM state enum, IN_W and BEAT_W defaults, and the derived constants DEPTH and NBEATS.
REQ-031 Table storage lives in one sub-module, neuron_lut_table, which is a DEPTH x 1 distributed-RAM array with a BEAT_W-wide write port and a 1-bit registered read port.

Verification
REQ-032 The bench covers these directed scenarios with IN_W=6 and BEAT_W=8:
- Load: beats 0..7 = 00,00,00,23,00,00,00,23 hex, cfg_last on beat 7 -> loaded=1; lookups 24,25,29,56,57,61 -> 1; lookups 0,26,30,63 -> 0, each 1 cycle after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending -> out_data stable, in_ready=0; release -> streaming at 1 result per cycle.
- Malformed load: cfg_last on beat 3 -> cfg_err pulses once, loaded=0, in_ready=0; then a full correct load -> loaded=1.
- Missing cfg_last on beat 7 -> cfg_err, FSM in EMPTY, and subsequent lookups are stalled.
- Reload from READY with in_valid=1 -> cfg_ready=0 until in_valid=0 and out_valid=0; the new all-FF table then gives lookup 0 -> 1.
- Assert rst_n=0 after beat 4 -> loaded=0, all table bits 0, cfg_err=0, out_valid=0.

Source files
------------

// File: rtl/neuron_lut_pkg.sv
// rtl/neuron_lut_pkg.sv - shared types and constants for the neuron LUT loader
package neuron_lut_pkg;

  localparam int IN_W_DEF   = 6;
  localparam int BEAT_W_DEF = 8;
  localparam int DEPTH      = 2 ** IN_W_DEF;
  localparam int NBEATS     = DEPTH / BEAT_W_DEF;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  // A single-beat table still needs a 1-bit counter to keep the port legal
  function automatic int cnt_width(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/neuron_lut_table.sv
// rtl/neuron_lut_table.sv - DEPTH x 1 truth-table storage, beat-wide write, registered 1-bit read
module neuron_lut_table
  import neuron_lut_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int CNT_W  = cnt_width((2 ** IN_W_DEF) / BEAT_W_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [CNT_W-1:0]  wbeat,
  input  logic [BEAT_W-1:0] wdata,
  input  logic              re,
  input  logic [IN_W-1:0]   raddr,
  output logic              rdata
);

  localparam int TBL_DEPTH = 2 ** IN_W;

  logic [TBL_DEPTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      rdata <= 1'b0;
    end else begin
      if (we) begin
        mem[int'(wbeat) * BEAT_W +: BEAT_W] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/neuron_lut_loader.sv
// rtl/neuron_lut_loader.sv - streams a truth table in by beats, then serves 1-bit lookups
module neuron_lut_loader
  import neuron_lut_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [BEAT_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              cfg_err,
  output logic              loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data
);

  localparam int TBL_DEPTH = 2 ** IN_W;
  localparam int TBL_BEATS = TBL_DEPTH / BEAT_W;
  localparam int CNT_W     = cnt_width(TBL_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TBL_BEATS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             final_beat;
  logic             good_beat;
  logic             bad_beat;
  logic             in_fire;

  assign final_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready signals and beat classification live together so the handshake
  // and the transition it causes are derived in one place.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b1;
    in_ready  = 1'b0;
    good_beat = 1'b0;
    bad_beat  = 1'b0;
    in_fire   = 1'b0;
    if (state == READY) begin
      cfg_ready = !out_valid && !in_valid;
      in_ready  = !out_valid || out_ready;
    end
    in_fire = in_valid && in_ready;
    if (cfg_valid && cfg_ready) begin
      if (cfg_last != final_beat) begin
        bad_beat  = 1'b1;
        state_nxt = EMPTY;
      end else begin
        good_beat = 1'b1;
        state_nxt = final_beat ? READY : LOADING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      loaded    <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cfg_err <= bad_beat;
      if (bad_beat) begin
        beat_cnt <= '0;
        loaded   <= 1'b0;
      end else if (good_beat) begin
        if (final_beat) begin
          beat_cnt <= '0;
          loaded   <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          loaded   <= 1'b0;
        end
      end
      if (in_fire) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // The read register only advances on an accepted lookup, which already
  // requires the output slot to be free, so it doubles as the output holder.
  neuron_lut_table #(
    .IN_W   (IN_W),
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (good_beat),
    .wbeat (beat_cnt),
    .wdata (cfg_data),
    .re    (in_fire),
    .raddr (in_data),
    .rdata (out_data)
  );

endmodule
